// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester and FIFO write-port signals shared by the
// round-robin write arbiter and its environment.
//   req / req_data  : per-requester level request and data (slot i at
//                     [i*DATA_WIDTH +: DATA_WIDTH])
//   gnt             : one-hot capture pulse back to the requesters
//   fifo_wr_en/fifo_data_in : FIFO write port
//   fifo_full/fifo_wr_ack   : FIFO status (wr_ack is registered in the FIFO)
// master = arbiter side, slave = requesters + FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_data_in;
    logic                          fifo_full;
    logic                          fifo_wr_ack;

    modport master (
        input  req, req_data, fifo_full, fifo_wr_ack,
        output gnt, fifo_wr_en, fifo_data_in
    );

    modport slave (
        output req, req_data, fifo_full, fifo_wr_ack,
        input  gnt, fifo_wr_en, fifo_data_in
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among
// NUM_REQ requesters. Each write is checked against the FIFO's registered
// wr_ack; an unacknowledged word is re-issued up to MAX_RETRY times and then
// dropped.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : fifo_wr_arbiter_if.master (req/req_data/gnt, FIFO write port)
//   busy       : state is not IDLE
//   drop       : one-cycle pulse when the held word is discarded
//   drop_id    : owner of the dropped word, valid with drop
//   wr_cnt     : acknowledged writes, saturating
//   drop_cnt   : dropped words, saturating
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_RETRY  = 2,
    parameter int CNT_WIDTH  = 16,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_wr_arbiter_if.master     bus,
    output logic                  busy,
    output logic                  drop,
    output logic [ID_W-1:0]       drop_id,
    output logic [CNT_WIDTH-1:0]  wr_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CHECK = 2'd2,
        RETRY = 2'd3
    } state_t;

    state_t                 state;
    logic [ID_W-1:0]        last;
    logic [2:0]             retry;
    logic [DATA_WIDTH-1:0]  hold;

    logic                   found;
    logic [ID_W-1:0]        winner;
    logic [ID_W-1:0]        scan_idx;
    logic [DATA_WIDTH-1:0]  win_data;

    // Search starts one past the previous winner so every requester gets a
    // turn before anyone is served twice.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            scan_idx = ID_W'((int'(last) + i) % NUM_REQ);
            if (!found && bus.req[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
        win_data = bus.req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            last             <= ID_W'(NUM_REQ - 1);
            retry            <= '0;
            hold             <= '0;
            bus.gnt          <= '0;
            bus.fifo_wr_en   <= 1'b0;
            bus.fifo_data_in <= '0;
            busy             <= 1'b0;
            drop             <= 1'b0;
            drop_id          <= '0;
            wr_cnt           <= '0;
            drop_cnt         <= '0;
        end else begin
            bus.gnt <= '0;
            drop    <= 1'b0;
            case (state)
                IDLE: begin
                    if (found && !bus.fifo_full) begin
                        hold             <= win_data;
                        bus.fifo_data_in <= win_data;
                        bus.fifo_wr_en   <= 1'b1;
                        bus.gnt          <= NUM_REQ'(1) << winner;
                        last             <= winner;
                        retry            <= '0;
                        busy             <= 1'b1;
                        state            <= WRITE;
                    end
                end
                WRITE: begin
                    bus.fifo_wr_en <= 1'b0;
                    state          <= CHECK;
                end
                CHECK: begin
                    if (bus.fifo_wr_ack) begin
                        if (wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (retry < RETRY_LIMIT) begin
                        retry <= retry + 1'b1;
                        state <= RETRY;
                    end else begin
                        drop    <= 1'b1;
                        drop_id <= last;
                        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                RETRY: begin
                    // Held word is re-sent from the local copy; requester data
                    // may already have moved on.
                    if (!bus.fifo_full) begin
                        bus.fifo_data_in <= hold;
                        bus.fifo_wr_en   <= 1'b1;
                        state            <= WRITE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic        busy;
    logic        drop;
    logic [1:0]  drop_id;
    logic [15:0] wr_cnt;
    logic [15:0] drop_cnt;

    logic        suppress;
    logic [15:0] fifo_q[$];
    int          n_cmp;
    int          n_bad;

    fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(16)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ(4), .DATA_WIDTH(16), .MAX_RETRY(2), .CNT_WIDTH(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.master),
        .busy     (busy),
        .drop     (drop),
        .drop_id  (drop_id),
        .wr_cnt   (wr_cnt),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: registered ack for every write it accepts, unless told to
    // withhold it.
    always @(posedge clk) begin
        if (rst) begin
            bus.fifo_wr_ack <= 1'b0;
        end else begin
            bus.fifo_wr_ack <= bus.fifo_wr_en && !suppress;
            if (bus.fifo_wr_en && !suppress) fifo_q.push_back(bus.fifo_data_in);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.fifo_full = 1'b0;
        suppress = 1'b0;
        tick();
        tick();
        fifo_q.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++; if (bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
            n_cmp++; if (bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", bus.fifo_wr_en); end
            n_cmp++; if (bus.fifo_data_in !== 16'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0000", bus.fifo_data_in); end
            n_cmp++; if ({busy, drop, drop_id} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {busy, drop, drop_id}); end
            n_cmp++; if ({wr_cnt, drop_cnt} !== 32'h0) begin n_bad++; $display("FAIL reset_cnts: got %h want 00000000", {wr_cnt, drop_cnt}); end
        end
        rst = 1'b0;
        tick();
        n_cmp++; if (bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL reset_first_gnt: got %b want 0001", bus.gnt); end
        n_cmp++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_data_in !== 16'hA000) begin n_bad++; $display("FAIL reset_first_wr: got %b/%h want 1/a000", bus.fifo_wr_en, bus.fifo_data_in); end
        bus.req = '0;
        tick();
        tick();
    endtask

    task automatic test_fairness();
        logic [3:0]  exp_gnt;
        logic [15:0] exp_data;
        do_reset();
        bus.req = 4'b1111;
        for (int c = 1; c <= 24; c++) begin
            tick();
            exp_gnt = (c % 3 == 1) ? (4'b0001 << ((c / 3) % 4)) : 4'b0000;
            n_cmp++; if (bus.gnt !== exp_gnt) begin n_bad++; $display("FAIL fair_gnt cycle %0d: got %b want %b", c, bus.gnt, exp_gnt); end
        end
        bus.req = '0;
        n_cmp++; if (wr_cnt !== 16'd8) begin n_bad++; $display("FAIL fair_wr_cnt: got %0d want 8", wr_cnt); end
        n_cmp++; if (fifo_q.size() != 8) begin n_bad++; $display("FAIL fair_fifo_size: got %0d want 8", fifo_q.size()); end
        for (int k = 0; k < 8 && k < fifo_q.size(); k++) begin
            exp_data = 16'hA000 + 16'(k % 4);
            n_cmp++; if (fifo_q[k] !== exp_data) begin n_bad++; $display("FAIL fair_order[%0d]: got %h want %h", k, fifo_q[k], exp_data); end
        end
        tick();
        tick();
    endtask

    task automatic test_full_stall();
        do_reset();
        bus.fifo_full = 1'b1;
        bus.req = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++; if (bus.fifo_wr_en !== 1'b0 || bus.gnt !== 4'b0000 || busy !== 1'b0) begin n_bad++; $display("FAIL stall_idle: got wr_en=%b gnt=%b busy=%b want 0/0000/0", bus.fifo_wr_en, bus.gnt, busy); end
        end
        bus.fifo_full = 1'b0;
        tick();
        n_cmp++; if (bus.gnt !== 4'b0010) begin n_bad++; $display("FAIL stall_release_gnt: got %b want 0010", bus.gnt); end
        n_cmp++; if (bus.fifo_data_in !== 16'hA001) begin n_bad++; $display("FAIL stall_release_data: got %h want a001", bus.fifo_data_in); end
        bus.req = '0;
        tick();
        tick();
        n_cmp++; if (wr_cnt !== 16'd1) begin n_bad++; $display("FAIL stall_wr_cnt: got %0d want 1", wr_cnt); end
    endtask

    task automatic test_retry_drop();
        int n_wr, n_gnt, n_drop, drop_cycle;
        logic [1:0] seen_id;
        logic [3:0] seen_gnt;
        do_reset();
        suppress = 1'b1;
        bus.req_data[3*16 +: 16] = 16'hABCD;
        bus.req = 4'b1000;
        n_wr = 0; n_gnt = 0; n_drop = 0; drop_cycle = 0; seen_id = '0; seen_gnt = '0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (bus.fifo_wr_en && bus.fifo_data_in == 16'hABCD) n_wr++;
            if (bus.gnt != 0) begin n_gnt++; seen_gnt = bus.gnt; bus.req = '0; end
            if (drop) begin n_drop++; seen_id = drop_id; drop_cycle = c; end
        end
        n_cmp++; if (n_wr != 3) begin n_bad++; $display("FAIL retry_wr_pulses: got %0d want 3", n_wr); end
        n_cmp++; if (n_gnt != 1 || seen_gnt !== 4'b1000) begin n_bad++; $display("FAIL retry_gnt: got %0d x %b want 1 x 1000", n_gnt, seen_gnt); end
        n_cmp++; if (n_drop != 1 || drop_cycle != 9) begin n_bad++; $display("FAIL retry_drop: got %0d at cycle %0d want 1 at 9", n_drop, drop_cycle); end
        n_cmp++; if (seen_id !== 2'd3) begin n_bad++; $display("FAIL retry_drop_id: got %0d want 3", seen_id); end
        n_cmp++; if (drop_cnt !== 16'd1 || wr_cnt !== 16'd0) begin n_bad++; $display("FAIL retry_cnts: got drop=%0d wr=%0d want 1/0", drop_cnt, wr_cnt); end
        suppress = 1'b0;
    endtask

    task automatic test_reset_in_check();
        int bad_cycles;
        do_reset();
        bus.req_data[0 +: 16] = 16'hA000;
        bus.req = 4'b0001;
        tick();
        n_cmp++; if (bus.fifo_wr_en !== 1'b1) begin n_bad++; $display("FAIL rchk_wr_en: got %b want 1", bus.fifo_wr_en); end
        bus.req = '0;
        tick();
        rst = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b0 || bus.fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL rchk_after_reset: got busy=%b wr_en=%b want 0/0", busy, bus.fifo_wr_en); end
        n_cmp++; if (wr_cnt !== 16'd0) begin n_bad++; $display("FAIL rchk_wr_cnt: got %0d want 0", wr_cnt); end
        rst = 1'b0;
        bad_cycles = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.fifo_wr_en !== 1'b0 || drop !== 1'b0 || busy !== 1'b0) bad_cycles++;
        end
        n_cmp++; if (bad_cycles != 0) begin n_bad++; $display("FAIL rchk_no_retry: got %0d active cycles want 0", bad_cycles); end
        n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL rchk_drop_cnt: got %0d want 0", drop_cnt); end
    endtask

    task automatic test_rotation();
        do_reset();
        bus.req = 4'b0001;
        tick();
        n_cmp++; if (bus.gnt !== 4'b0001) begin n_bad++; $display("FAIL rot_seed: got %b want 0001", bus.gnt); end
        bus.req = '0;
        tick();
        tick();
        bus.req = 4'b0100;
        tick();
        n_cmp++; if (bus.gnt !== 4'b0100) begin n_bad++; $display("FAIL rot_to_2: got %b want 0100", bus.gnt); end
        bus.req = '0;
        tick();
        tick();
        bus.req = 4'b1010;
        tick();
        n_cmp++; if (bus.gnt !== 4'b1000) begin n_bad++; $display("FAIL rot_to_3: got %b want 1000", bus.gnt); end
        tick();
        n_cmp++; if (bus.gnt !== 4'b0000) begin n_bad++; $display("FAIL rot_busy_gap: got %b want 0000", bus.gnt); end
        tick();
        tick();
        n_cmp++; if (bus.gnt !== 4'b0010) begin n_bad++; $display("FAIL rot_to_1: got %b want 0010", bus.gnt); end
        bus.req = '0;
        tick();
        tick();
        n_cmp++; if (wr_cnt !== 16'd4) begin n_bad++; $display("FAIL rot_wr_cnt: got %0d want 4", wr_cnt); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        suppress = 1'b0;
        bus.fifo_full = 1'b0;
        bus.req = '0;
        for (int i = 0; i < 4; i++) bus.req_data[i*16 +: 16] = 16'hA000 + 16'(i);
        test_reset();
        test_fairness();
        test_full_stall();
        test_retry_drop();
        for (int i = 0; i < 4; i++) bus.req_data[i*16 +: 16] = 16'hA000 + 16'(i);
        test_reset_in_check();
        test_rotation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
